// File: rtl/param_sequence_pattern_detector.sv
// -----------------------------------------------------------------------------
// param_sequence_pattern_detector
//
// Serial pattern detector with a pattern and length that can be changed at
// runtime. The pattern is 1..MAX_LEN bits long. Matches can be overlapping or
// non-overlapping. The match pulse is registered, so it appears on the clock
// edge after the final bit of the pattern is accepted.
//
// Build option:
//   SEQ_DET_MATCH_COUNT_EN - adds the input cnt_clr and the output match_count.
//                            match_count is a saturating counter of match
//                            pulses, CNT_W bits wide.
//
// Ports:
//   clk          clock; every state update happens on posedge
//   rest         synchronous reset, active-high
//   in_valid     qualifies in; state advances only when high
//   in           serial data bit
//   overlap      1 = overlapping matches, 0 = non-overlapping
//   cfg_load     loads cfg_pattern/cfg_len and clears the bit history
//   cfg_pattern  new pattern, LSB-aligned (pattern[len-1] is sent first)
//   cfg_len      new pattern length (clamped to 1..MAX_LEN)
//   out          registered match pulse
//   cur_len      active pattern length after clamping
//   cnt_clr      (option) clears match_count, wins over an increment
//   match_count  (option) saturating count of match pulses
// -----------------------------------------------------------------------------
module param_sequence_pattern_detector #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = 4,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'h35,
    parameter int                 DEF_LEN     = 6
`ifdef SEQ_DET_MATCH_COUNT_EN
    ,
    parameter int                 CNT_W       = 16
`endif
) (
    input  logic               clk,
    input  logic               rest,
    input  logic               in_valid,
    input  logic               in,
    input  logic               overlap,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
`ifdef SEQ_DET_MATCH_COUNT_EN
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   match_count,
`endif
    output logic               out,
    output logic [LEN_W-1:0]   cur_len
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] DEF_LEN_L = LEN_W'(DEF_LEN);

    logic [MAX_LEN-1:0] pattern_reg;
    logic [LEN_W-1:0]   len_reg;
    // Only MAX_LEN-1 history bits need storage. The incoming bit supplies the
    // newest position of the compare window.
    logic [MAX_LEN-2:0] hist_reg;
    logic [LEN_W-1:0]   fill_reg;
    logic               out_reg;

    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W:0]     fill_plus;
    logic               fill_ok;
    logic               pattern_ok;
    logic               accept;
    logic               match_hit;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W-1:0]   cfg_len_clamped;

    // The history after this cycle's bit has been shifted in.
    assign hist_shift = {hist_reg, in};

    // Mask that selects the low len bits. Pattern bits above len are ignored.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign len_mask[gi] = (32'(gi) < 32'(len_reg));
        end
    endgenerate

    assign accept     = in_valid & ~cfg_load;
    assign fill_plus  = {1'b0, fill_reg} + 1'b1;
    assign fill_ok    = (fill_plus >= {1'b0, len_reg});
    assign pattern_ok = (((hist_shift ^ pattern_reg) & len_mask) == '0);
    assign match_hit  = accept & fill_ok & pattern_ok;

    // The fill count stops at MAX_LEN. No larger window is ever needed.
    assign fill_inc = (fill_reg == MAX_LEN_L) ? fill_reg : fill_plus[LEN_W-1:0];

    always_comb begin
        cfg_len_clamped = cfg_len;
        if (cfg_len == '0) begin
            cfg_len_clamped = LEN_W'(1);
        end else if (32'(cfg_len) > MAX_LEN) begin
            cfg_len_clamped = MAX_LEN_L;
        end
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            pattern_reg <= DEF_PATTERN;
            len_reg     <= DEF_LEN_L;
            hist_reg    <= '0;
            fill_reg    <= '0;
            out_reg     <= 1'b0;
        end else if (cfg_load) begin
            // A bit that arrives in the same cycle as a load is discarded.
            pattern_reg <= cfg_pattern;
            len_reg     <= cfg_len_clamped;
            hist_reg    <= '0;
            fill_reg    <= '0;
            out_reg     <= 1'b0;
        end else if (in_valid) begin
            hist_reg <= hist_shift[MAX_LEN-2:0];
            out_reg  <= match_hit;
            if (match_hit && !overlap) begin
                fill_reg <= '0;
            end else begin
                fill_reg <= fill_inc;
            end
        end else begin
            out_reg <= 1'b0;
        end
    end

    assign out     = out_reg;
    assign cur_len = len_reg;

`ifdef SEQ_DET_MATCH_COUNT_EN
    logic [CNT_W-1:0] match_count_reg;

    // The counter steps on the same edge that raises out, so it stays in step
    // with the pulse.
    always_ff @(posedge clk) begin
        if (rest) begin
            match_count_reg <= '0;
        end else if (cnt_clr) begin
            match_count_reg <= '0;
        end else if (match_hit && (match_count_reg != '1)) begin
            match_count_reg <= match_count_reg + 1'b1;
        end
    end

    assign match_count = match_count_reg;
`endif

endmodule

// File: tb/tb_param_sequence_pattern_detector.sv
module tb_param_sequence_pattern_detector;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               rest = 1'b0;
    logic               in_valid = 1'b0;
    logic               in = 1'b0;
    logic               overlap = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               out;
    logic [LEN_W-1:0]   cur_len;
`ifdef SEQ_DET_MATCH_COUNT_EN
    logic               cnt_clr = 1'b0;
    logic [1:0]         match_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    param_sequence_pattern_detector #(
        .MAX_LEN     (MAX_LEN),
        .LEN_W       (LEN_W),
        .DEF_PATTERN (8'h35),
        .DEF_LEN     (6)
`ifdef SEQ_DET_MATCH_COUNT_EN
        ,
        .CNT_W       (2)
`endif
    ) dut (
        .clk         (clk),
        .rest        (rest),
        .in_valid    (in_valid),
        .in          (in),
        .overlap     (overlap),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
`ifdef SEQ_DET_MATCH_COUNT_EN
        .cnt_clr     (cnt_clr),
        .match_count (match_count),
`endif
        .out         (out),
        .cur_len     (cur_len)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after posedge. Outputs are sampled at the same
    // point, so the value seen reflects the edge that just happened.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        in_valid = 1'b1;
        in       = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load_cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l);
        cfg_load    = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        tick();
        cfg_load    = 1'b0;
    endtask

    task automatic test_reset();
        rest = 1'b1;
        tick();
        rest = 1'b0;
        n_assert++;
        if (out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: got %b expected 0", out);
        end
        n_assert++;
        if (cur_len !== 4'd6) begin
            n_fail++;
            $display("FAIL reset_len: got %0d expected 6", cur_len);
        end
        $display("reset: out=%b cur_len=%0d", out, cur_len);
    endtask

    task automatic test_default_pattern();
        logic [5:0] bits;
        logic [5:0] exp;
        bits = 6'b110101;   // MSB sent first
        exp  = 6'b000001;   // pulse only after the 6th bit
        overlap = 1'b0;
        for (int i = 5; i >= 0; i--) begin
            drive_bit(bits[i]);
            n_assert++;
            if (out !== exp[i]) begin
                n_fail++;
                $display("FAIL default_bit%0d: got %b expected %b", 5 - i, out, exp[i]);
            end
            $display("default: bit%0d in=%b out=%b", 5 - i, bits[i], out);
        end
        tick();
        n_assert++;
        if (out !== 1'b0) begin
            n_fail++;
            $display("FAIL default_pulse_width: got %b expected 0", out);
        end
    endtask

    task automatic run_1010(input logic ov, input logic [5:0] exp);
        logic [5:0] bits;
        bits = 6'b101010;
        load_cfg(8'b0000_1010, 4'd4);
        overlap = ov;
        n_assert++;
        if (cur_len !== 4'd4) begin
            n_fail++;
            $display("FAIL cfg_len4: got %0d expected 4", cur_len);
        end
        for (int i = 5; i >= 0; i--) begin
            drive_bit(bits[i]);
            n_assert++;
            if (out !== exp[i]) begin
                n_fail++;
                $display("FAIL ov%0d_bit%0d: got %b expected %b", ov, 5 - i, out, exp[i]);
            end
            $display("overlap=%0d: bit%0d in=%b out=%b", ov, 5 - i, bits[i], out);
        end
    endtask

    task automatic test_overlap();
        run_1010(1'b1, 6'b000101);   // pulses after bits 4 and 6
    endtask

    task automatic test_non_overlap();
        run_1010(1'b0, 6'b000100);   // one pulse, after bit 4
    endtask

    task automatic test_gaps();
        logic [5:0] bits;
        int gaps [6] = '{0, 1, 2, 3, 2, 1};
        bits = 6'b110101;
        overlap = 1'b0;
        test_reset();
        for (int i = 0; i < 6; i++) begin
            drive_bit(bits[5 - i]);
            n_assert++;
            if (out !== (i == 5)) begin
                n_fail++;
                $display("FAIL gap_bit%0d: got %b expected %b", i, out, (i == 5));
            end
            $display("gaps: bit%0d out=%b gap=%0d", i, out, gaps[i]);
            for (int g = 0; g < gaps[i]; g++) begin
                tick();
                n_assert++;
                if (out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gap_idle%0d_%0d: got %b expected 0", i, g, out);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [5:0] bits;
        bits = 6'b110101;
        test_reset();
        for (int i = 5; i >= 2; i--) drive_bit(bits[i]);
        test_reset();
        for (int i = 1; i >= 0; i--) begin
            drive_bit(bits[i]);
            n_assert++;
            if (out !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_bit%0d: got %b expected 0", 1 - i, out);
            end
            $display("reset midstream: tail bit in=%b out=%b", bits[i], out);
        end
    endtask

    task automatic test_load_collision();
        logic [5:0] bits;
        bits = 6'b110101;
        test_reset();
        for (int i = 5; i >= 1; i--) drive_bit(bits[i]);
        // The 6th bit arrives in the same cycle as a load and must be discarded.
        in_valid = 1'b1;
        in       = 1'b1;
        load_cfg(8'h35, 4'd6);
        in_valid = 1'b0;
        n_assert++;
        if (out !== 1'b0) begin
            n_fail++;
            $display("FAIL load_collision: got %b expected 0", out);
        end
        $display("load collision: out=%b", out);
        // The history was cleared, so a lone 1 cannot complete the pattern.
        drive_bit(1'b1);
        n_assert++;
        if (out !== 1'b0) begin
            n_fail++;
            $display("FAIL load_cleared_hist: got %b expected 0", out);
        end
    endtask

    task automatic test_clamp();
        load_cfg(8'h00, 4'd0);
        n_assert++;
        if (cur_len !== 4'd1) begin
            n_fail++;
            $display("FAIL clamp_zero: got %0d expected 1", cur_len);
        end
        $display("clamp: cfg_len=0 cur_len=%0d", cur_len);
        load_cfg(8'h00, 4'd12);
        n_assert++;
        if (cur_len !== 4'd8) begin
            n_fail++;
            $display("FAIL clamp_max: got %0d expected 8", cur_len);
        end
        $display("clamp: cfg_len=12 cur_len=%0d", cur_len);
    endtask

    task automatic test_len1();
        logic [3:0] bits;
        bits = 4'b1011;
        // Bits above len are ignored, and 8'hA5 has bit0 = 1.
        load_cfg(8'hA5, 4'd1);
        overlap = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            drive_bit(bits[i]);
            n_assert++;
            if (out !== bits[i]) begin
                n_fail++;
                $display("FAIL len1_bit%0d: got %b expected %b", 3 - i, out, bits[i]);
            end
            $display("len1: in=%b out=%b", bits[i], out);
        end
    endtask

`ifdef SEQ_DET_MATCH_COUNT_EN
    task automatic test_match_count();
        logic [1:0] exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        test_reset();
        load_cfg(8'h01, 4'd1);
        for (int i = 0; i < 5; i++) begin
            drive_bit(1'b1);
            n_assert++;
            if (match_count !== exp[i]) begin
                n_fail++;
                $display("FAIL count_%0d: got %0d expected %0d", i, match_count, exp[i]);
            end
            $display("count: match %0d match_count=%0d", i, match_count);
        end
        cnt_clr = 1'b1;
        drive_bit(1'b1);
        cnt_clr = 1'b0;
        n_assert++;
        if (match_count !== 2'd0) begin
            n_fail++;
            $display("FAIL count_clr: got %0d expected 0", match_count);
        end
        $display("count: clr with match out=%b match_count=%0d", out, match_count);
    endtask
`endif

    initial begin
        test_reset();
        test_default_pattern();
        test_overlap();
        test_non_overlap();
        test_gaps();
        test_reset_midstream();
        test_load_collision();
        test_clamp();
        test_len1();
`ifdef SEQ_DET_MATCH_COUNT_EN
        test_match_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/param_sequence_pattern_detector.md
Name: param_sequence_pattern_detector

Overview:
Parametrised successor to the fixed-pattern serial detector. It takes a serial bit stream with a valid qualifier and detects a runtime-programmable pattern of 1..MAX_LEN bits. Overlapping or non-overlapping matching is selectable. The registered match pulse follows the existing detector style: the output is a function of registered state only. It sits on the serial receive path and feeds framing/sync logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32)
LEN_W, 4, width of length fields; must hold MAX_LEN
DEF_PATTERN, 8'h35, pattern loaded at reset (LSB-aligned; 6'b110101)
DEF_LEN, 6, pattern length loaded at reset (1..MAX_LEN)
CNT_W, 16, match counter width (optional feature only)

Ports:
clk  input  1  clock; all state updates on posedge
rest  input  1  synchronous reset, active-high
in_valid  input  1  qualifies in; state advances only when high
in  input  1  serial data bit
overlap  input  1  1 = overlapping matches, 0 = non-overlapping; sampled every cycle
cfg_load  input  1  load cfg_pattern/cfg_len, clear history
cfg_pattern  input  MAX_LEN  new pattern, LSB-aligned
cfg_len  input  LEN_W  new pattern length
out  output  1  match pulse, registered
cur_len  output  LEN_W  active pattern length after clamping

Behaviour:
- Reset (rest=1 at posedge):
  - out=0; history register hist=0; fill count=0.
  - pattern=DEF_PATTERN; len=DEF_LEN.
  - rest overrides every other input, including mid-stream; partial matches are discarded.
- Bit order:
  - pattern[len-1] is the first bit of the sequence; pattern[0] is the last.
  - On each accepted bit, hist shifts left and in enters hist[0].
- Fill count:
  - Counts accepted bits since the last clear; saturates at MAX_LEN.
- Match condition, evaluated on an accepted bit (in_valid=1, cfg_load=0):
  - fill+1 >= len, and
  - the low len bits of the shifted history equal pattern[len-1:0].
- Latency:
  - out goes high on the posedge after the cycle that accepted the final bit.
  - out stays high exactly one cycle.
  - out=0 in any cycle following a non-accepted or non-matching bit.
- overlap=1: fill count is unaffected by a match; the pattern tail may begin the next match.
- overlap=0: on a match, fill resets to 0; the next match needs len fresh bits.
- in_valid=0: hist, fill and pattern hold; out deasserts after one cycle. Gaps of any length between valid bits are transparent.
- cfg_load=1:
  - Latches pattern=cfg_pattern and len=clamp(cfg_len); clears hist and fill; next out=0.
  - Clamp rule: cfg_len=0 becomes 1; cfg_len>MAX_LEN becomes MAX_LEN.
  - If in_valid is high in the same cycle, cfg_load wins and the bit is discarded.
- cur_len reflects the latched len and updates on the posedge of the load.
- Pattern bits above len are ignored in the comparison.
- len=1: every accepted bit equal to pattern[0] produces a pulse. With overlap=0 this is the same.

Optional Feature:
- Macro: SEQ_DET_MATCH_COUNT_EN.
- Defined:
  - Adds output match_count [CNT_W-1:0] and input cnt_clr [1].
  - match_count increments on every out pulse and saturates at all-ones (no wrap).
  - cnt_clr=1 forces match_count to 0, taking priority over a simultaneous increment.
  - Reset value 0; cfg_load does not clear it.
- Undefined: neither port exists and no counter logic is present; all other behaviour is identical.

Test Plan:
- Default config after reset, overlap=0, bits 1,1,0,1,0,1 on consecutive cycles -> out=1 only on the posedge after the 6th bit; out=0 on every other cycle.
- cfg_load pattern 4'b1010, len=4, overlap=1, bits 1,0,1,0,1,0 -> pulses after bits 4 and 6.
- Same pattern with overlap=0, same bits -> one pulse, after bit 4 only.
- Default config, bits 1,1,0,1,0,1 with in_valid=0 gaps of 0-3 cycles between bits -> exactly one pulse, on the posedge after the 6th valid bit.
- Default config, rest=1 after bits 1,1,0,1 then bits 0,1 -> no pulse. Separately, cfg_load in the same cycle as the 6th bit -> no pulse.
- cfg_len=0 -> cur_len=1. cfg_len=12 with MAX_LEN=8 -> cur_len=8.
- With SEQ_DET_MATCH_COUNT_EN and CNT_W=2: 5 matches -> match_count=3. Then cnt_clr asserted in the same cycle as a match -> match_count=0.
